// File: rtl/tlk2711_rx_frame_checker.sv
// Receive-side frame checker for a TLK2711 link: tracks SYNC/SOF framing, validates the
// header, data pattern, checksum and EOF of each frame, and keeps frame/error statistics.
module tlk2711_rx_frame_checker #(
  parameter logic [15:0] HEAD0     = 16'hEB90,
  parameter logic [15:0] HEAD1     = 16'hE116,
  parameter logic [15:0] EXP_LEN   = 16'h0366,
  parameter int          ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_soft_rst,
  input  logic                 i_enable,
  input  logic                 i_clear_err,
  input  logic                 i_rkmsb,
  input  logic                 i_rklsb,
  input  logic [15:0]          i_rxd,
  input  logic [1:0]           i_pattern_mode,
  input  logic [15:0]          i_pattern_seed,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic                 o_frame_ok,
  output logic                 o_check_error,
  output logic [3:0]           o_error_status,
  output logic [31:0]          o_frame_cnt,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_SYNC, ST_HOF0, ST_HOF1, ST_FEND,
    ST_FCNT, ST_LEN, ST_DATA, ST_CSUM, ST_EOF
  } state_t;

  localparam logic [15:0] LAST_WORD = EXP_LEN / 16'd2 - 16'd1;

  state_t               r_state, w_nextState;
  logic                 r_rkmsb, r_rklsb;
  logic [15:0]          r_rxd;
  logic [15:0]          r_expData, r_csum, r_wordCnt, r_lastFcnt;
  logic                 r_firstFrame, r_frameErr;
  logic                 r_frameDone, r_frameOk, r_checkError;
  logic [3:0]           r_errorStatus;
  logic [31:0]          r_frameCnt;
  logic [ERR_CNT_W-1:0] r_errCnt;

  logic [3:0]  w_errCode;
  logic        w_abort, w_frameEnd, w_frameOkNext, w_kAny;
  logic        w_isSync, w_isSof, w_isEof, w_enterData;
  logic [15:0] w_expWord;
  logic        w_anyRst;

  assign w_anyRst  = rst | i_soft_rst;
  assign w_kAny    = r_rkmsb | r_rklsb;
  assign w_isSync  = !r_rkmsb && r_rklsb && (r_rxd == 16'hC5BC);
  assign w_isSof   = r_rkmsb && r_rklsb && (r_rxd == 16'h5CFB);
  assign w_isEof   = r_rkmsb && r_rklsb && (r_rxd == 16'hFDFE);
  assign w_expWord = (i_pattern_mode == 2'd2) ? i_pattern_seed : r_expData;

  always_ff @(posedge clk) begin
    if (w_anyRst) begin
      r_rkmsb <= 1'b0;
      r_rklsb <= 1'b0;
      r_rxd   <= 16'd0;
    end else begin
      r_rkmsb <= i_rkmsb;
      r_rklsb <= i_rklsb;
      r_rxd   <= i_rxd;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_errCode   = 4'd0;
    w_frameEnd  = 1'b0;
    if (!i_enable) begin
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_isSync) w_nextState = ST_SYNC;
        ST_SYNC: begin
          if (w_isSof) w_nextState = ST_HOF0;
          else if (!w_isSync) begin
            w_errCode   = 4'd1;
            w_nextState = ST_IDLE;
          end
        end
        ST_HOF0: begin
          if (w_kAny) w_errCode = 4'd10;
          else if (r_rxd != HEAD0) w_errCode = 4'd2;
          w_nextState = ST_HOF1;
        end
        ST_HOF1: begin
          if (w_kAny) w_errCode = 4'd10;
          else if (r_rxd != HEAD1) w_errCode = 4'd3;
          w_nextState = ST_FEND;
        end
        ST_FEND: begin
          if (w_kAny) w_errCode = 4'd10;
          else if (r_rxd > 16'd1) w_errCode = 4'd4;
          w_nextState = ST_FCNT;
        end
        ST_FCNT: begin
          if (w_kAny) w_errCode = 4'd10;
          else if (!r_firstFrame && (r_rxd != r_lastFcnt + 16'd1)) w_errCode = 4'd5;
          w_nextState = ST_LEN;
        end
        ST_LEN: begin
          if (w_kAny) w_errCode = 4'd10;
          else if (r_rxd != EXP_LEN) w_errCode = 4'd6;
          w_nextState = ST_DATA;
        end
        ST_DATA: begin
          if (w_kAny) w_errCode = 4'd10;
          else if (r_rxd != w_expWord) w_errCode = 4'd7;
          if (r_wordCnt == LAST_WORD) w_nextState = ST_CSUM;
        end
        ST_CSUM: begin
          if (w_kAny) w_errCode = 4'd10;
          else if (r_rxd != r_csum) w_errCode = 4'd8;
          w_nextState = ST_EOF;
        end
        ST_EOF: begin
          if (!w_isEof) w_errCode = 4'd9;
          w_frameEnd  = 1'b1;
          w_nextState = ST_IDLE;
        end
        default: w_nextState = ST_IDLE;
      endcase
    end
    // Header and K-flag errors end the frame immediately; data, checksum and EOF errors do not.
    w_abort = ((w_errCode >= 4'd2) && (w_errCode <= 4'd6)) || (w_errCode == 4'd10);
    if (w_abort) w_nextState = ST_IDLE;
  end

  assign w_frameOkNext = w_frameEnd && !r_frameErr && (w_errCode == 4'd0);
  assign w_enterData   = i_enable && (r_state == ST_LEN) && (w_nextState == ST_DATA);

  always_ff @(posedge clk) begin
    if (w_anyRst) begin
      r_state       <= ST_IDLE;
      r_frameDone   <= 1'b0;
      r_frameOk     <= 1'b0;
      r_frameErr    <= 1'b0;
      r_checkError  <= 1'b0;
      r_errorStatus <= 4'd0;
      r_frameCnt    <= 32'd0;
      r_errCnt      <= '0;
    end else begin
      r_state     <= w_nextState;
      r_frameDone <= w_frameEnd | w_abort;
      r_frameOk   <= w_frameOkNext;
      if (r_state == ST_SYNC) r_frameErr <= 1'b0;
      else if (w_errCode != 4'd0) r_frameErr <= 1'b1;
      if (w_frameEnd | w_abort) begin
        r_frameCnt <= r_frameCnt + 32'd1;
        if (!w_frameOkNext && (r_errCnt != '1)) r_errCnt <= r_errCnt + ERR_CNT_W'(1);
      end
      // A clear in the same cycle as a new error still lets that error's code through.
      if (w_errCode != 4'd0) begin
        r_checkError <= 1'b1;
        if (!r_checkError || i_clear_err) r_errorStatus <= w_errCode;
      end else if (i_clear_err) begin
        r_checkError  <= 1'b0;
        r_errorStatus <= 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_anyRst) begin
      r_expData    <= i_pattern_seed;
      r_firstFrame <= 1'b1;
      r_lastFcnt   <= 16'd0;
      r_csum       <= 16'd0;
      r_wordCnt    <= 16'd0;
    end else if (!i_enable) begin
      r_firstFrame <= 1'b1;
    end else begin
      if (r_state == ST_FCNT) begin
        r_lastFcnt   <= r_rxd;
        r_firstFrame <= 1'b0;
      end
      if (w_enterData) begin
        r_wordCnt <= 16'd0;
        r_csum    <= 16'd0;
        if (i_pattern_mode == 2'd1) r_expData <= i_pattern_seed;
      end else if (r_state == ST_DATA) begin
        r_wordCnt <= r_wordCnt + 16'd1;
        r_csum    <= r_csum + r_rxd;
        r_expData <= r_expData + 16'd1;
      end
    end
  end

  assign o_busy         = (r_state != ST_IDLE) && (r_state != ST_SYNC);
  assign o_frame_done   = r_frameDone;
  assign o_frame_ok     = r_frameOk;
  assign o_check_error  = r_checkError;
  assign o_error_status = r_errorStatus;
  assign o_frame_cnt    = r_frameCnt;
  assign o_err_cnt      = r_errCnt;

endmodule

// File: tb/tb_tlk2711_rx_frame_checker.sv
// Scoreboard bench for tlk2711_rx_frame_checker: each frame pushes its expected o_frame_ok,
// a monitor pops it on every o_frame_done, and status/counters are checked between frames.
module tb_tlk2711_rx_frame_checker;

  localparam int NWORDS = 435;

  logic        clk = 1'b0;
  logic        rst, i_soft_rst, i_enable, i_clear_err;
  logic        i_rkmsb, i_rklsb;
  logic [15:0] i_rxd;
  logic [1:0]  i_pattern_mode;
  logic [15:0] i_pattern_seed;
  logic        o_busy, o_frame_done, o_frame_ok, o_check_error;
  logic [3:0]  o_error_status;
  logic [31:0] o_frame_cnt;
  logic [15:0] o_err_cnt;

  logic        okQ[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] model;

  always #5 clk = ~clk;

  tlk2711_rx_frame_checker dut (
    .clk(clk), .rst(rst), .i_soft_rst(i_soft_rst), .i_enable(i_enable),
    .i_clear_err(i_clear_err), .i_rkmsb(i_rkmsb), .i_rklsb(i_rklsb), .i_rxd(i_rxd),
    .i_pattern_mode(i_pattern_mode), .i_pattern_seed(i_pattern_seed),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_frame_ok(o_frame_ok),
    .o_check_error(o_check_error), .o_error_status(o_error_status),
    .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic km, input logic kl, input logic [15:0] d);
    @(posedge clk); #1;
    i_rkmsb = km;
    i_rklsb = kl;
    i_rxd   = d;
  endtask

  task automatic idleWords(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0000);
  endtask

  task automatic softReset();
    @(posedge clk); #1;
    i_soft_rst = 1'b1;
    @(posedge clk); #1;
    i_soft_rst = 1'b0;
    model = i_pattern_seed;
    idleWords(2);
  endtask

  task automatic clearErr();
    @(posedge clk); #1;
    i_clear_err = 1'b1;
    @(posedge clk); #1;
    i_clear_err = 1'b0;
    idleWords(2);
  endtask

  task automatic sendFrame(input logic [15:0] fcnt, input int badWord, input bit badCsum,
                           input bit badHead, input bit badFcnt, input bit badEof,
                           input bit clrAtEof);
    logic [15:0] csum;
    logic [15:0] w;
    okQ.push_back(badWord < 0 && !badCsum && !badHead && !badFcnt && !badEof);
    applyStimulus(1'b0, 1'b1, 16'hC5BC);
    applyStimulus(1'b0, 1'b1, 16'hC5BC);
    applyStimulus(1'b1, 1'b1, 16'h5CFB);
    applyStimulus(1'b0, 1'b0, badHead ? 16'hEB91 : 16'hEB90);
    if (badHead) begin
      idleWords(4);
      return;
    end
    applyStimulus(1'b0, 1'b0, 16'hE116);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, fcnt);
    if (badFcnt) begin
      idleWords(4);
      return;
    end
    applyStimulus(1'b0, 1'b0, 16'h0366);
    csum = 16'h0000;
    for (int i = 0; i < NWORDS; i++) begin
      if (i_pattern_mode == 2'd2) w = i_pattern_seed;
      else if (i_pattern_mode == 2'd1) w = i_pattern_seed + 16'(i);
      else begin
        w = model;
        model = model + 16'd1;
      end
      if (i == badWord) w = w ^ 16'h0100;
      csum = csum + w;
      applyStimulus(1'b0, 1'b0, w);
    end
    applyStimulus(1'b0, 1'b0, badCsum ? csum + 16'd1 : csum);
    applyStimulus(1'b1, 1'b1, badEof ? 16'hFDFF : 16'hFDFE);
    @(posedge clk); #1;
    i_clear_err = clrAtEof;
    i_rkmsb = 1'b0; i_rklsb = 1'b0; i_rxd = 16'h0000;
    @(posedge clk); #1;
    i_clear_err = 1'b0;
    idleWords(3);
  endtask

  // Every done pulse must match the oldest outstanding frame expectation.
  always @(negedge clk) begin
    if (o_frame_done) begin
      if (okQ.size() == 0) checkOutput("spuriousDone", {31'd0, o_frame_done}, 32'd0);
      else checkOutput("frameOk", {31'd0, o_frame_ok}, {31'd0, okQ.pop_front()});
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; i_soft_rst = 1'b0; i_enable = 1'b1; i_clear_err = 1'b0;
    i_rkmsb = 1'b0; i_rklsb = 1'b0; i_rxd = 16'h0000;
    i_pattern_mode = 2'd0; i_pattern_seed = 16'h0000;
    model = 16'h0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rstFrameCnt", o_frame_cnt, 32'd0);
    checkOutput("rstErrCnt", {16'd0, o_err_cnt}, 32'd0);
    checkOutput("rstCheckErr", {31'd0, o_check_error}, 32'd0);
    checkOutput("rstStatus", {28'd0, o_error_status}, 32'd0);
    checkOutput("rstBusy", {31'd0, o_busy}, 32'd0);

    for (int f = 0; f < 3; f++) sendFrame(16'(f), -1, 0, 0, 0, 0, 0);
    checkOutput("goodFrameCnt", o_frame_cnt, 32'd3);
    checkOutput("goodErrCnt", {16'd0, o_err_cnt}, 32'd0);
    checkOutput("goodCheckErr", {31'd0, o_check_error}, 32'd0);

    sendFrame(16'd3, -1, 0, 1, 0, 0, 0);
    checkOutput("badHeadStatus", {28'd0, o_error_status}, 32'd2);
    checkOutput("badHeadBusy", {31'd0, o_busy}, 32'd0);
    sendFrame(16'd3, -1, 0, 0, 0, 0, 0);
    checkOutput("afterHeadCnt", o_frame_cnt, 32'd5);
    checkOutput("afterHeadErrCnt", {16'd0, o_err_cnt}, 32'd1);
    clearErr();
    checkOutput("clearStatus", {28'd0, o_error_status}, 32'd0);
    checkOutput("clearCheckErr", {31'd0, o_check_error}, 32'd0);

    softReset();
    checkOutput("softRstFrameCnt", o_frame_cnt, 32'd0);
    sendFrame(16'd100, 10, 0, 0, 0, 0, 0);
    checkOutput("dataErrStatus", {28'd0, o_error_status}, 32'd7);
    sendFrame(16'd101, -1, 1, 0, 0, 0, 0);
    sendFrame(16'd102, -1, 0, 0, 0, 0, 0);
    checkOutput("csumStatus", {28'd0, o_error_status}, 32'd7);
    checkOutput("dataErrCnt", {16'd0, o_err_cnt}, 32'd2);
    checkOutput("dataFrameCnt", o_frame_cnt, 32'd3);

    softReset();
    sendFrame(16'hFFFF, -1, 0, 0, 0, 0, 0);
    sendFrame(16'h0000, -1, 0, 0, 0, 0, 0);
    checkOutput("wrapCheckErr", {31'd0, o_check_error}, 32'd0);
    checkOutput("wrapErrCnt", {16'd0, o_err_cnt}, 32'd0);
    softReset();
    sendFrame(16'd5, -1, 0, 0, 0, 0, 0);
    sendFrame(16'd7, -1, 0, 0, 1, 0, 0);
    checkOutput("fcntStatus", {28'd0, o_error_status}, 32'd5);
    checkOutput("fcntErrCnt", {16'd0, o_err_cnt}, 32'd1);

    sendFrame(16'd8, -1, 0, 0, 0, 1, 1);
    checkOutput("clrEofCheckErr", {31'd0, o_check_error}, 32'd1);
    checkOutput("clrEofStatus", {28'd0, o_error_status}, 32'd9);
    checkOutput("clrEofErrCnt", {16'd0, o_err_cnt}, 32'd2);

    applyStimulus(1'b0, 1'b1, 16'hC5BC);
    applyStimulus(1'b1, 1'b1, 16'h5CFB);
    applyStimulus(1'b0, 1'b0, 16'hEB90);
    applyStimulus(1'b0, 1'b0, 16'hE116);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'd9);
    applyStimulus(1'b0, 1'b0, 16'h0366);
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, 16'(600 + i));
    @(negedge clk);
    checkOutput("busyInData", {31'd0, o_busy}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model = i_pattern_seed;
    idleWords(4);
    checkOutput("midRstFrameCnt", o_frame_cnt, 32'd0);
    checkOutput("midRstErrCnt", {16'd0, o_err_cnt}, 32'd0);
    checkOutput("midRstStatus", {28'd0, o_error_status}, 32'd0);
    checkOutput("midRstCheckErr", {31'd0, o_check_error}, 32'd0);
    checkOutput("midRstBusy", {31'd0, o_busy}, 32'd0);
    sendFrame(16'h1234, -1, 0, 0, 0, 0, 0);

    applyStimulus(1'b0, 1'b1, 16'hC5BC);
    applyStimulus(1'b1, 1'b1, 16'h5CFB);
    applyStimulus(1'b0, 1'b0, 16'hEB90);
    @(posedge clk); #1 i_enable = 1'b0;
    idleWords(2);
    checkOutput("disableBusy", {31'd0, o_busy}, 32'd0);
    checkOutput("disableCheckErr", {31'd0, o_check_error}, 32'd0);
    i_enable = 1'b1;
    sendFrame(16'h0500, -1, 0, 0, 0, 0, 0);

    i_pattern_mode = 2'd2; i_pattern_seed = 16'hA5A5;
    sendFrame(16'h0501, -1, 0, 0, 0, 0, 0);
    i_pattern_mode = 2'd1; i_pattern_seed = 16'h0010;
    sendFrame(16'h0502, -1, 0, 0, 0, 0, 0);
    sendFrame(16'h0503, -1, 0, 0, 0, 0, 0);

    idleWords(2);
    checkOutput("finalFrameCnt", o_frame_cnt, 32'd5);
    checkOutput("finalErrCnt", {16'd0, o_err_cnt}, 32'd0);
    checkOutput("finalCheckErr", {31'd0, o_check_error}, 32'd0);
    checkOutput("finalStatus", {28'd0, o_error_status}, 32'd0);
    checkOutput("pendingFrames", okQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tlk2711_rx_frame_checker.md
TLK2711_RX_FRAME_CHECKER -- requirements
Module: tlk2711_rx_frame_checker

Interface
REQ-001 Parameter HEAD0, 16'hEB90, first frame-header word.
REQ-002 Parameter HEAD1, 16'hE116, second frame-header word.
REQ-003 Parameter EXP_LEN, 16'h0366, expected payload length in bytes; must be even and at least 2; payload words = EXP_LEN/2.
REQ-004 Parameter ERR_CNT_W, 16, width of the error counter.
REQ-005 Port list: clock and reset first.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- i_soft_rst  in  1  software reset; same effect as rst.
- i_enable  in  1  checker enable.
- i_clear_err  in  1  clears the sticky error flag and error code.
- i_rkmsb  in  1  TLK2711 K-flag, upper byte.
- i_rklsb  in  1  TLK2711 K-flag, lower byte.
- i_rxd  in  16  TLK2711 receive data.
- i_pattern_mode  in  2  0 = incrementing, continuous across frames; 1 = incrementing, restarts every frame; 2 = constant; 3 = same as 0.
- i_pattern_seed  in  16  pattern start value or constant.
- o_busy  out  1  FSM is not in IDLE or SYNC.
- o_frame_done  out  1  one-cycle pulse at the end of a frame.
- o_frame_ok  out  1  valid with o_frame_done; 1 when the frame had no error.
- o_check_error  out  1  sticky error flag.
- o_error_status  out  4  code of the first error since the last clear.
- o_frame_cnt  out  32  count of completed frames (wraps).
- o_err_cnt  out  ERR_CNT_W  count of erroneous frames (saturates).

Function
REQ-006 Input stage: i_rxd, i_rkmsb and i_rklsb are registered once; the FSM evaluates only the registered values.
REQ-007 Word definitions:
- SYNC word = rkmsb 0, rklsb 1, data 16'hC5BC.
- SOF word = both K-flags 1, data 16'h5CFB.
- EOF word = both K-flags 1, data 16'hFDFE.
REQ-008 FSM states: IDLE, SYNC, HOF0, HOF1, FEND, FCNT, LEN, DATA, CSUM, EOF.
REQ-009 IDLE -> SYNC on a SYNC word while i_enable=1; all other words are ignored without error.
REQ-010 SYNC transitions:
- SYNC word: stay in SYNC.
- SOF word: go to HOF0.
- Any other word: error code 1, go to IDLE.
REQ-011 Header states advance one word per cycle in the order HOF0, HOF1, FEND, FCNT, LEN, DATA.
REQ-012 HOF0 word must equal HEAD0, else code 2.
REQ-013 HOF1 word must equal HEAD1, else code 3.
REQ-014 FEND word must be 0 or 1, else code 4.
REQ-015 FCNT word must equal previous FCNT + 1, modulo 2^16; else code 5.
REQ-016 The first frame after reset, soft reset or re-enable accepts any FCNT value; the received FCNT value is always stored.
REQ-017 LEN word must equal EXP_LEN, else code 6.
REQ-018 Any set K-flag in HOF0 through CSUM gives code 10.
REQ-019 Codes 2-6 and 10 abort the frame:
- o_frame_done=1 and o_frame_ok=0 on the next cycle;
- FSM returns to IDLE.
REQ-020 DATA lasts exactly EXP_LEN/2 cycles; a 16-bit word counter zeroes on entry to DATA and exits to CSUM when count = EXP_LEN/2 - 1.
REQ-021 Expected data per word:
- mode 0: starts at i_pattern_seed after reset or soft reset, +1 per data word, carried across frames;
- mode 1: reloads i_pattern_seed on entry to DATA;
- mode 2: constant i_pattern_seed.
REQ-022 The expected value advances on every data word whether it matches or not.
REQ-023 A data mismatch gives code 7 and does not abort; checking continues to the end of the frame.
REQ-024 The checksum is the 16-bit wrap-around sum of received data words. The CSUM word must equal it, else code 8.
REQ-025 The EOF-state word must be an EOF word, else code 9.
REQ-026 The FSM goes to IDLE after EOF. o_frame_done pulses the cycle after the EOF word is evaluated; o_frame_ok = 1 only if no code was raised in that frame.
REQ-027 On every o_frame_done pulse:
- o_frame_cnt increments;
- o_err_cnt increments when o_frame_ok=0, saturating at all-ones.
REQ-028 Any error code sets o_check_error. o_error_status loads the code only while o_check_error=0, so the first error is held.
REQ-029 i_clear_err zeroes o_check_error and o_error_status; a new error in the same cycle wins and loads its code.
REQ-030 i_enable=0 forces IDLE on the next cycle with no frame_done and no error; counters hold.
REQ-031 Code 1 does not pulse o_frame_done and does not count in o_err_cnt.

Reset
REQ-032 On rst or i_soft_rst the following SHALL occur on the next clock edge:
- FSM to IDLE;
- all outputs to 0;
- expected-data register to i_pattern_seed;
- first-frame flag set;
- checksum and word counter to 0.
REQ-033 Reset mid-frame SHALL discard the frame with no o_frame_done pulse.

Verification
REQ-034 Good frames: mode 0, seed 0, three frames with FCNT 0,1,2 and data 0..434, 435..869, 870..1304 -> three o_frame_done pulses with o_frame_ok=1; o_frame_cnt=3; o_err_cnt=0; o_check_error=0.
REQ-035 Bad header: HOF0=16'hEB91 -> o_frame_done and o_frame_ok=0 on the next cycle; o_error_status=2; FSM back in IDLE; the next good frame is accepted.
REQ-036 Data errors: data word 10 corrupted, then a checksum error in a later frame -> o_error_status stays 7; o_err_cnt=2; the frame length is unaffected.
REQ-037 FCNT wrap: FCNT 16'hFFFF followed by 0 -> no error; FCNT 5 followed by 7 -> code 5.
REQ-038 Clear and reset: i_clear_err coincident with a new code 9 -> o_check_error=1 and o_error_status=9. rst asserted during DATA -> outputs 0, no o_frame_done, next frame's FCNT accepted freely.
